// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: single-outstanding instruction fetch.
// Fetches the word at pc, holds it until downstream consumes it, then
// redirects pc sequentially or by the branch offset. A misaligned target
// parks the unit in FAULT until reset.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] offset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        take;     // fetch response accepted this cycle
  logic        consume;  // held instruction leaves this cycle
  logic        misalign;

  assign take     = (state == FETCH) && imem_ready;
  assign consume  = (state == HOLD) && !stall;
  // jump/offset only matter in the consume cycle; elsewhere next_pc is unused
  assign next_pc  = jump ? (inst_pc + offset) : (inst_pc + 32'd4);
  assign misalign = (next_pc[1:0] != 2'b00);

  // request is a pure decode of state so reset drops it immediately
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (take) state_nxt = HOLD;
      HOLD:    if (consume) state_nxt = misalign ? FAULT : FETCH;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: capture fetched word, redirect pc, count retirements
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      fault      <= 1'b0;
      retired    <= '0;
    end else begin
      if (take) begin
        inst       <= imem_rdata;
        inst_pc    <= pc;
        inst_valid <= 1'b1;
      end
      if (consume) begin
        inst_valid <= 1'b0;
        retired    <= retired + 32'd1;
        if (misalign) fault <= 1'b1;
        else          pc    <= next_pc;
      end
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port stall  in  1  downstream not ready; the held instruction is not consumed.
REQ-004 SHALL have port jump  in  1  branch decision for the held instruction, from the branch unit.
REQ-005 SHALL have port offset  in  32  sign-extended byte offset for the held instruction, from the branch unit.
REQ-006 SHALL have port imem_req  out  1  instruction-memory read request.
REQ-007 SHALL have port imem_addr  out  32  instruction-memory read address.
REQ-008 SHALL have port imem_ready  in  1  read data valid this cycle.
REQ-009 SHALL have port imem_rdata  in  32  read data.
REQ-010 SHALL have port inst  out  32  held instruction word.
REQ-011 SHALL have port inst_pc  out  32  address of the held instruction.
REQ-012 SHALL have port inst_valid  out  1  inst/inst_pc valid.
REQ-013 SHALL have port fault  out  1  misaligned-target fault, sticky.
REQ-014 SHALL have port retired  out  32  count of consumed instructions.
REQ-015 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address.

Function
REQ-016 SHALL implement the FSM states IDLE, FETCH, HOLD and FAULT, held in a registered state variable.
REQ-017 SHALL go from IDLE to FETCH unconditionally one cycle after reset deasserts.
REQ-018 SHALL, in FETCH, drive imem_req=1 and imem_addr=pc; all other states SHALL drive imem_req=0 and imem_addr=pc.
REQ-019 SHALL, in FETCH with imem_ready=1, register inst<=imem_rdata, inst_pc<=pc and inst_valid<=1, then go to HOLD.
REQ-020 SHALL, in FETCH with imem_ready=0, remain in FETCH with pc unchanged and no timeout.
REQ-021 SHALL, in HOLD with stall=1, keep inst, inst_pc and inst_valid constant and ignore jump and offset.
REQ-022 SHALL define consumption as HOLD with stall=0, and SHALL sample jump and offset only in that cycle.
REQ-023 SHALL compute the next pc on consumption as inst_pc+offset if jump=1, else inst_pc+4, using 32-bit modulo arithmetic (wrap, no overflow flag).
REQ-024 SHALL, on consumption with next-pc bits [1:0]=0, load pc, clear inst_valid, increment retired and go to FETCH.
REQ-025 SHALL, on consumption with next-pc bits [1:0]!=0, set fault=1, clear inst_valid, increment retired, leave pc unchanged and go to FAULT.
REQ-026 SHALL, in FAULT, keep imem_req=0 and inst_valid=0 and stay in FAULT until reset.
REQ-027 SHALL give a latency of 1 cycle from imem_ready=1 to inst_valid=1, and 1 cycle from consumption to the next imem_req=1.
REQ-028 SHALL wrap retired from 32'hFFFF_FFFF to 0.
REQ-029 SHALL ignore imem_ready when not in FETCH.

Reset
REQ-030 SHALL, while rst=1, force state=IDLE, pc=RESET_PC, inst=0, inst_pc=0, inst_valid=0, fault=0, retired=0, imem_req=0, imem_addr=RESET_PC, independent of clk.
REQ-031 SHALL, when rst asserts mid-FETCH, abort the outstanding request; imem_ready arriving while rst=1 or in IDLE SHALL be ignored.

Verification
REQ-032 SHALL cover: reset release with imem_ready=1 and rdata=0x00000013 -> IDLE 1 cycle, then imem_addr=0x0, then inst_valid=1, inst_pc=0x0 and inst=0x13.
REQ-033 SHALL cover: sequential flow with stall=0 and jump=0 over 3 instructions -> imem_addr sequence 0x0, 0x4, 0x8 and retired=3.
REQ-034 SHALL cover: inst_pc=0x10 with jump=1 and offset=0xFFFFFFF8 on consumption -> next imem_addr=0x08.
REQ-035 SHALL cover: stall=1 for 5 cycles with jump and offset toggling -> inst and inst_pc stable, no imem_req, and after stall drops the target uses only the consumption-cycle values.
REQ-036 SHALL cover: imem_ready held low 10 cycles -> imem_req high and imem_addr stable throughout, then inst_valid 1 cycle after ready.
REQ-037 SHALL cover: jump=1 with offset=0x2 -> fault=1, imem_req=0 permanently, and rst clears fault and restarts at RESET_PC.
